// File: rtl/branch_unit_pkg.sv
// rtl/branch_unit_pkg.sv - shared definitions for branch resolution
// Contents:
//   XLEN_DEFAULT - default operand width
//   F3BR_*       - B-type funct3 branch condition encodings (f3Br group)
package branch_unit_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] F3BR_EQ   = 3'b000;
    localparam logic [2:0] F3BR_NE   = 3'b001;
    localparam logic [2:0] F3BR_RSV0 = 3'b010;
    localparam logic [2:0] F3BR_RSV1 = 3'b011;
    localparam logic [2:0] F3BR_LT   = 3'b100;
    localparam logic [2:0] F3BR_GE   = 3'b101;
    localparam logic [2:0] F3BR_LTU  = 3'b110;
    localparam logic [2:0] F3BR_GEU  = 3'b111;

endpackage

// File: rtl/branch_cmp.sv
// rtl/branch_cmp.sv - combinational operand comparator for branch resolution
// Ports:
//   rs1, rs2 - XLEN-bit source operands
//   eq       - rs1 == rs2
//   lt_s     - rs1 < rs2, two's complement
//   lt_u     - rs1 < rs2, unsigned
module branch_cmp
    import branch_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            eq,
    output logic            lt_s,
    output logic            lt_u
);

    always_comb begin
        eq   = (rs1 == rs2);
        lt_u = (rs1 < rs2);
        // Differing sign bits decide a signed compare outright: the negative
        // operand is the smaller one. Matching signs reduce to unsigned order.
        if (rs1[XLEN-1] != rs2[XLEN-1]) begin
            lt_s = rs1[XLEN-1];
        end else begin
            lt_s = lt_u;
        end
    end

endmodule

// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - RV32I conditional branch resolution, execute stage
// Optional macro: BRANCH_STATS_EN adds br_count / taken_count counters.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   branch            - current instruction is a conditional branch
//   funct3            - branch condition (F3BR_* encodings)
//   rs1, rs2          - source operands
//   taken, illegal    - combinational decision / reserved-funct3 flag
//   taken_q, illegal_q- registered copies, one cycle later
//   br_count          - legal branches seen (BRANCH_STATS_EN only)
//   taken_count       - taken branches seen (BRANCH_STATS_EN only)
module branch_unit
    import branch_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            branch,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken,
    output logic            illegal,
    output logic            taken_q,
`ifdef BRANCH_STATS_EN
    output logic            illegal_q,
    output logic [31:0]     br_count,
    output logic [31:0]     taken_count
`else
    output logic            illegal_q
`endif
);

    logic eq;
    logic lt_s;
    logic lt_u;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .rs1  (rs1),
        .rs2  (rs2),
        .eq   (eq),
        .lt_s (lt_s),
        .lt_u (lt_u)
    );

    // The default arm covers unknown funct3 so taken never picks up X.
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        if (branch) begin
            case (funct3)
                F3BR_EQ:   taken = eq;
                F3BR_NE:   taken = ~eq;
                F3BR_LT:   taken = lt_s;
                F3BR_GE:   taken = ~lt_s;
                F3BR_LTU:  taken = lt_u;
                F3BR_GEU:  taken = ~lt_u;
                F3BR_RSV0,
                F3BR_RSV1: illegal = 1'b1;
                default: begin
                    taken   = 1'b0;
                    illegal = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            taken_q   <= taken;
            illegal_q <= illegal;
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count    <= 32'd0;
            taken_count <= 32'd0;
        end else begin
            if (branch && !illegal) begin
                br_count <= br_count + 32'd1;
            end
            if (taken) begin
                taken_count <= taken_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_unit.sv
// tb/tb_branch_unit.sv - self-checking bench for branch_unit
module tb_branch_unit;

    logic        clk;
    logic        rst;
    logic        branch;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        taken;
    logic        illegal;
    logic        taken_q;
    logic        illegal_q;
`ifdef BRANCH_STATS_EN
    logic [31:0] br_count;
    logic [31:0] taken_count;
`endif

    int checks   = 0;
    int failures = 0;

    branch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .branch      (branch),
        .funct3      (funct3),
        .rs1         (rs1),
        .rs2         (rs2),
        .taken       (taken),
        .illegal     (illegal),
        .taken_q     (taken_q),
`ifdef BRANCH_STATS_EN
        .illegal_q   (illegal_q),
        .br_count    (br_count),
        .taken_count (taken_count)
`else
        .illegal_q   (illegal_q)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: operands widened to 64 bits so comparisons are plain
    // integer arithmetic. Returns {illegal, taken}.
    function automatic logic [1:0] model(input logic b, input logic [2:0] f,
                                         input logic [31:0] a, input logic [31:0] c);
        longint sa, sc, ua, uc;
        logic t;
        sa = longint'($signed(a));
        sc = longint'($signed(c));
        ua = longint'({32'd0, a});
        uc = longint'({32'd0, c});
        if (!b) return 2'b00;
        case (f)
            3'd0: t = (ua == uc);
            3'd1: t = (ua != uc);
            3'd4: t = (sa <  sc);
            3'd5: t = (sa >= sc);
            3'd6: t = (ua <  uc);
            3'd7: t = (ua >= uc);
            default: return 2'b10;
        endcase
        return {1'b0, t};
    endfunction

    // Drive at negedge, check combinational outputs, then check the
    // registered copies after the following posedge.
    task automatic apply(input string tag, input logic b, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] c);
        logic [1:0] exp;
        @(negedge clk);
        branch = b;
        funct3 = f;
        rs1    = a;
        rs2    = c;
        exp    = model(b, f, a, c);
        #1;
        check({tag, ".taken"},   {31'd0, taken},   {31'd0, exp[0]});
        check({tag, ".illegal"}, {31'd0, illegal}, {31'd0, exp[1]});
        @(posedge clk);
        #1;
        check({tag, ".taken_q"},   {31'd0, taken_q},   {31'd0, exp[0]});
        check({tag, ".illegal_q"}, {31'd0, illegal_q}, {31'd0, exp[1]});
    endtask

    task automatic direct(input string tag, input logic b, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] c, input logic exp_t);
        @(negedge clk);
        branch = b;
        funct3 = f;
        rs1    = a;
        rs2    = c;
        #1;
        check({tag, ".fixed"}, {31'd0, taken}, {31'd0, exp_t});
    endtask

    initial begin
        rst    = 1'b1;
        branch = 1'b0;
        funct3 = 3'd0;
        rs1    = 32'd0;
        rs2    = 32'd0;
        #2;
        check("reset.taken_q",   {31'd0, taken_q},   32'd0);
        check("reset.illegal_q", {31'd0, illegal_q}, 32'd0);
`ifdef BRANCH_STATS_EN
        check("reset.br_count",    br_count,    32'd0);
        check("reset.taken_count", taken_count, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Fixed expectations from the condition table
        direct("eq_t",   1, 3'd0, 32'hdeadbeef, 32'hdeadbeef, 1);
        direct("ne_t",   1, 3'd1, 32'hbeeff00d, 32'hcafef00d, 1);
        direct("lt_t",   1, 3'd4, 32'hfedcba98, 32'h12345678, 1);
        direct("ge_t",   1, 3'd5, 32'h76543210, 32'hfedcba98, 1);
        direct("ltu_t",  1, 3'd6, 32'h76543210, 32'h87654321, 1);
        direct("geu_t",  1, 3'd7, 32'hfedcba98, 32'h01234567, 1);
        direct("eq_n",   1, 3'd0, 32'hfeedf00d, 32'hf00dfeed, 0);
        direct("ne_n",   1, 3'd1, 32'hfeedc0de, 32'hfeedc0de, 0);
        direct("lt_n",   1, 3'd4, 32'h76543210, 32'h87654321, 0);
        direct("ge_n",   1, 3'd5, 32'hfedcba98, 32'h01234567, 0);
        direct("ltu_n",  1, 3'd6, 32'hfedcba98, 32'h12345678, 0);
        direct("geu_n",  1, 3'd7, 32'h76543210, 32'hfedcba98, 0);
        direct("bnd_lt",  1, 3'd4, 32'h80000000, 32'h7fffffff, 1);
        direct("bnd_ltu", 1, 3'd6, 32'h80000000, 32'h7fffffff, 0);
        direct("bnd_ge",  1, 3'd5, 32'h80000000, 32'h7fffffff, 0);
        direct("bnd_geu", 1, 3'd7, 32'h80000000, 32'h7fffffff, 1);
        direct("z_ge",   1, 3'd5, 32'd0, 32'd0, 1);
        direct("z_geu",  1, 3'd7, 32'd0, 32'd0, 1);
        direct("z_lt",   1, 3'd4, 32'd0, 32'd0, 0);
        direct("z_ltu",  1, 3'd6, 32'd0, 32'd0, 0);

        // Gating and reserved codes, also through the registered path
        apply("gate", 0, 3'd0, 32'h12345678, 32'h12345678);
        apply("rsv2", 1, 3'd2, 32'h1, 32'h1);
        apply("rsv3", 1, 3'd3, 32'h1, 32'h2);
        apply("eq_reg", 1, 3'd0, 32'hdeadbeef, 32'hdeadbeef);

        // Reset between edges clears registers at once; comb path keeps going
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst.taken_q", {31'd0, taken_q}, 32'd0);
        check("midrst.taken",   {31'd0, taken},   32'd1);
        rst = 1'b0;

        // Randomized sweep
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a, c;
            logic        b;
            a = $urandom;
            c = $urandom;
            case ($urandom_range(0, 5))
                0: c = a;
                1: begin a = 32'h80000000; c = 32'h7fffffff; end
                2: c = a ^ 32'h80000000;
                default: ;
            endcase
            b = ($urandom_range(0, 9) != 0);
            apply("rand", b, 3'($urandom_range(0, 7)), a, c);
        end

`ifdef BRANCH_STATS_EN
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            branch = 1; funct3 = 3'd0; rs1 = 32'h55; rs2 = 32'h55;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            branch = 1; funct3 = 3'd1; rs1 = 32'h55; rs2 = 32'h55;
        end
        @(negedge clk);
        branch = 0;
        check("stats.br_count",    br_count,    32'd8);
        check("stats.taken_count", taken_count, 32'd5);
        rst = 1'b1;
        #1;
        check("stats.rst_br",    br_count,    32'd0);
        check("stats.rst_taken", taken_count, 32'd0);
        rst = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
- RV32I conditional-branch resolution block in the execute stage.
- Compares two 32-bit register operands per the B-type funct3 and outputs a combinational taken flag to PC-select logic.
- Also provides registered copies (taken_q, illegal_q) for the downstream pipeline stage.

Parameters:
XLEN, 32, operand width in bits.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous active-high reset.
branch  input  1  current instruction is a conditional branch.
funct3  input  3  branch condition, encoded per the shared f3Br constants.
rs1  input  XLEN  first source operand.
rs2  input  XLEN  second source operand.
taken  output  1  combinational branch-taken decision.
illegal  output  1  combinational flag: branch=1 with a reserved funct3.
taken_q  output  1  taken, registered on the rising edge of clk.
illegal_q  output  1  illegal, registered on the rising edge of clk.

Behaviour:
- Encodings: EQ=3'b000, NE=3'b001, LT=3'b100, GE=3'b101, LTU=3'b110, GEU=3'b111.
- Reserved funct3 values: 3'b010 and 3'b011.
- taken is purely combinational, zero cycles from any input change; it does not depend on clk or rst.
- EQ: rs1==rs2. NE: rs1!=rs2.
- LT: signed rs1<rs2 (two's complement). GE: signed rs1>=rs2.
- LTU: unsigned rs1<rs2. GEU: unsigned rs1>=rs2.
- branch=0 forces taken=0 and illegal=0, regardless of the other inputs.
- Reserved funct3 with branch=1: taken=0, illegal=1.
- X/undriven funct3 must not propagate X to taken; the default case arm drives 0.
- Equal operands: EQ, GE and GEU are taken; NE, LT and LTU are not taken.
- Sign boundary: rs1=32'h80000000, rs2=32'h7fffffff gives LT taken and LTU not taken.
- Registered outputs: taken_q and illegal_q load taken and illegal on every posedge clk, giving one cycle of latency.
- Reset: rst=1 asynchronously clears taken_q=0 and illegal_q=0 (and the counters, if compiled in).
- Reset asserted mid-operation clears the registers immediately. The combinational outputs keep evaluating during reset.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - Adds outputs br_count[31:0] and taken_count[31:0].
  - br_count increments on each posedge clk with branch=1 and illegal=0.
  - taken_count increments on each posedge clk with taken=1.
  - Both counters wrap modulo 2^32 and clear on rst.
- Undefined: these ports and the counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package f3Br, in the common definitions header, holds the six 3-bit funct3 constants: EQ, NE, LT, GE, LTU, GEU.
- XLEN default also lives in the shared definitions.
- One sub-module, branch_cmp (purely combinational), produces eq, lt_s and lt_u from rs1 and rs2.
- branch_unit does the funct3 mux, the illegal decode, the output registers and the optional counters.

Test Plan:
- Taken, all conditions, branch=1:
  - EQ: deadbeef/deadbeef -> taken=1.
  - NE: beeff00d/cafef00d -> 1.
  - LT: fedcba98/12345678 -> 1.
  - GE: 76543210/fedcba98 -> 1.
  - LTU: 76543210/87654321 -> 1.
  - GEU: fedcba98/01234567 -> 1.
- Not taken, all conditions, branch=1:
  - EQ: feedf00d/f00dfeed -> 0.
  - NE: feedc0de/feedc0de -> 0.
  - LT: 76543210/87654321 -> 0.
  - GE: fedcba98/01234567 -> 0.
  - LTU: fedcba98/12345678 -> 0.
  - GEU: 76543210/fedcba98 -> 0.
- Gating and reserved codes:
  - branch=0, EQ, equal operands -> taken=0, illegal=0.
  - branch=1, funct3=3'b010 -> taken=0, illegal=1.
  - branch=1, funct3=3'b011 -> taken=0, illegal=1.
- Boundaries:
  - rs1=80000000, rs2=7fffffff: LT=1, LTU=0, GE=0, GEU=1.
  - rs1=rs2=0: GE=1, GEU=1, LT=0, LTU=0.
- Registered path:
  - taken_q follows taken exactly one clk later.
  - rst pulsed between edges clears taken_q=0 immediately while taken stays 1.
- BRANCH_STATS_EN:
  - 5 clocks of taken EQ plus 3 clocks of not-taken NE -> br_count=8, taken_count=5.
  - rst -> both counters 0.
